// File: rtl/bus_invert_decoder.sv
// Bus-invert receiver: restores the data word, flags invert-rule violations, counts switching.
// Latency 1 cycle from in_valid to out_valid/data_out/rule_err and counter update.
// No backpressure: every in_valid beat is consumed; no ready signal exists.
//
// Ports:
//   clk, rst         - rising-edge clock; asynchronous active-high reset
//   in_valid         - bus_in/inv_in carry a beat this cycle
//   bus_in, inv_in   - coded bus lines and the accompanying invert line
//   clr_stats        - synchronous clear of all statistics counters (wins over a beat's increments)
//   out_valid        - data_out/rule_err valid this cycle
//   data_out         - decoded word
//   rule_err         - the beat's invert line disagreed with the invert rule
//   bus_toggles      - saturating count of transitions on the WIDTH+1 coded lines
//   data_toggles     - saturating count of transitions on the decoded word
//   err_count        - saturating count of rule_err beats
//
// Build option: define BIC_DEC_STATS_EN to build the statistics counters. Without it the
// three count outputs are tied to 0 and clr_stats is ignored; decode and rule check are unchanged.
// WIDTH must be even and >= 2.

module bus_invert_decoder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             inv_in,
    input  logic             clr_stats,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             rule_err,
    output logic [CNT_W-1:0] bus_toggles,
    output logic [CNT_W-1:0] data_toggles,
    output logic [CNT_W-1:0] err_count
);

    // Wide enough to hold a popcount of WIDTH+1 lines.
    localparam int PC_W = $clog2(WIDTH + 2);
    localparam logic [PC_W-1:0] HALF = PC_W'(WIDTH / 2);

    function automatic logic [PC_W-1:0] popcount_d(input logic [WIDTH-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + {{(PC_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Decode and rule check
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] prev_dec;
    logic [WIDTH-1:0] dec;
    logic [PC_W-1:0]  hd;
    logic             expect_inv;
    logic             err_nxt;

    assign dec        = inv_in ? ~bus_in : bus_in;
    assign hd         = popcount_d(dec ^ prev_dec);
    // A tie (exactly half the lines) must not be inverted.
    assign expect_inv = (hd > HALF);
    assign err_nxt    = (inv_in != expect_inv);

    // An erroneous beat still advances the history, so one bad beat does not
    // cascade into errors on the following beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            rule_err  <= 1'b0;
            prev_dec  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out <= dec;
                rule_err <= err_nxt;
                prev_dec <= dec;
            end
        end
    end

`ifdef BIC_DEC_STATS_EN
    // ------------------------------------------------------------------
    // Switching statistics
    // ------------------------------------------------------------------
    function automatic logic [PC_W-1:0] popcount_b(input logic [WIDTH:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            c = c + {{(PC_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Add one cycle's increment at CNT_W+1 bits; a carry out means the
    // counter would wrap, so clamp to all-ones instead.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic [PC_W-1:0]  inc);
        logic [CNT_W:0] s;
        s = {1'b0, c} + {{(CNT_W+1-PC_W){1'b0}}, inc};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    logic [WIDTH:0]  prev_bus;
    logic [WIDTH:0]  cur_bus;
    logic [PC_W-1:0] bus_pc;

    assign cur_bus = {inv_in, bus_in};
    assign bus_pc  = popcount_b(cur_bus ^ prev_bus);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_bus     <= '0;
            bus_toggles  <= '0;
            data_toggles <= '0;
            err_count    <= '0;
        end else begin
            if (in_valid) begin
                prev_bus <= cur_bus;
            end
            // Clear takes priority over a coincident beat's increments.
            if (clr_stats) begin
                bus_toggles  <= '0;
                data_toggles <= '0;
                err_count    <= '0;
            end else if (in_valid) begin
                bus_toggles  <= sat_add(bus_toggles, bus_pc);
                data_toggles <= sat_add(data_toggles, hd);
                err_count    <= sat_add(err_count, {{(PC_W-1){1'b0}}, err_nxt});
            end
        end
    end
`else
    assign bus_toggles  = '0;
    assign data_toggles = '0;
    assign err_count    = '0;

    // clr_stats has no function without the counters.
    logic unused_clr_stats;
    assign unused_clr_stats = clr_stats;
`endif

endmodule

// File: doc/bus_invert_decoder.md
# bus_invert_decoder

Receive-side counterpart of the bus-invert encoder. It takes the coded bus plus its invert line, restores the original data word, and checks every beat against the invert rule (invert asserted exactly when the new word differs from the previous word in more than WIDTH/2 bits). It sits at the far end of the low-power bus, in front of the consuming logic, and can optionally count switched lines so that capacitance savings can be measured in silicon.

## Interface
- WIDTH, 8, data/bus width in bits; must be even, ≥2
- CNT_W, 16, width of each statistics counter
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset: rst, asynchronous, active-high; clock clk
- in_valid  input  1  bus_in/inv_in carry a beat this cycle
- bus_in  input  WIDTH  coded bus lines
- inv_in  input  1  invert line accompanying bus_in
- clr_stats  input  1  synchronous clear of all statistics counters
- out_valid  output  1  data_out/rule_err valid this cycle
- data_out  output  WIDTH  decoded word
- rule_err  output  1  beat violated the invert rule
- bus_toggles  output  CNT_W  accumulated transitions on the WIDTH+1 coded lines
- data_toggles  output  CNT_W  accumulated transitions on the decoded word
- err_count  output  CNT_W  accumulated rule_err beats

## Operation
- Decode: dec = inv_in ? ~bus_in : bus_in.
- State registers:
  - prev_dec (WIDTH) holds the last decoded word.
  - prev_bus (WIDTH+1) holds the last {inv_in, bus_in}.
- Rule check:
  - hd = popcount(dec ^ prev_dec).
  - Expected invert = (hd > WIDTH/2); hd == WIDTH/2 expects 0.
  - rule_err = (inv_in != expected).
- Accepted beat (in_valid=1):
  - Register data_out ← dec, rule_err ← check result, out_valid ← 1.
  - Update prev_dec ← dec and prev_bus ← {inv_in, bus_in}.
  - An erroneous beat still updates both.
- in_valid=0:
  - out_valid ← 0.
  - data_out and rule_err hold their last values.
  - prev_dec, prev_bus and the counters are unchanged.
- Statistics, updated on each accepted beat:
  - bus_toggles += popcount({inv_in,bus_in} ^ prev_bus).
  - data_toggles += popcount(dec ^ prev_dec).
  - err_count += rule_err.
  - All counters saturate at 2^CNT_W−1 and never wrap.
- clr_stats=1 sets all three counters to 0 on that edge. If it coincides with a beat, the clear wins and that beat's increments are discarded; data_out, prev_dec and prev_bus still update normally.
- No backpressure. Every in_valid beat is consumed.

## Timing
- Latency 1 cycle: a beat sampled at edge N appears on data_out/out_valid/rule_err after edge N, and the counters reflect it after edge N.
- Back-to-back beats give full throughput, one per cycle.
- Reset values, applied immediately on rst assertion:
  - out_valid=0, data_out=0, rule_err=0.
  - prev_dec=0 and prev_bus=0, which matches the encoder's reset state.
  - All counters=0.
- Reset asserted mid-stream discards the in-flight beat. The first beat after reset is checked against prev_dec=0.
- Counter arithmetic uses popcounts of width clog2(WIDTH+2), zero-extended. The saturating add is computed at CNT_W+1 bits and clamped.

## Configuration
- BIC_DEC_STATS_EN:
  - Defined: bus_toggles, data_toggles, err_count and the clr_stats logic are built as described.
  - Undefined: the counter registers and popcount-for-stats logic are not synthesized; the three count outputs are tied to 0 and clr_stats is ignored.
  - In both cases the decode path, rule_err and prev_dec are unaffected.

## Test plan
- After reset, send beat bus=0x00 inv=1, then bus=0x0F inv=0 → data_out 0xFF then 0x0F, rule_err 0 both beats; bus_toggles=6, data_toggles=12, err_count=0 (with BIC_DEC_STATS_EN).
- After reset, send bus=0xF0 inv=1 → data_out 0x0F, hd=4, expected 0, so rule_err=1 and err_count=1.
- Send beat, idle 3 cycles (in_valid=0), send bus=0x0F inv=0 → out_valid low during the idles, data_out holds, counters unchanged; the next beat is checked against the pre-idle word.
- Drive bus_toggles to saturation by preloading through a long stream of alternating 0x00/inv0 and 0xFF/inv0 beats with CNT_W=4 → the counter stops at 15; asserting clr_stats together with a beat gives 0 on the next cycle.
- Assert rst asynchronously mid-stream, between edges → out_valid, data_out and the counters drop to 0 without waiting for a clock edge; the next beat bus=0x00 inv=1 decodes to 0xFF with rule_err 0.
- Build without BIC_DEC_STATS_EN and rerun scenario 1 → identical data_out/rule_err; all count outputs constantly 0.
